// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select, load-use stall and branch-flush generator for the EX stage.
// Define HAZARD_STATS_EN to build the stall/flush event counters; otherwise both count ports read 0.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_is_load,
    input  logic                  ex_branch_taken,
    output logic                  fwd_a_mem,
    output logic                  fwd_a_wb,
    output logic                  fwd_b_mem,
    output logic                  fwd_b_wb,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rw;
        logic                  ld;
    } ex_ent_t;

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rw;
        logic                  ld;
    } mem_ent_t;

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rw;
    } wb_ent_t;

    ex_ent_t  ex_q;
    mem_ent_t mem_q;
    wb_ent_t  wb_q;

    logic lu;
    logic bubble_e;
    logic fa_mem, fa_wb, fb_mem, fb_wb;

    // A MEM-stage load never needs a different path (lu already spaced it out), so ld stops here.
    logic unused_mem_ld;
    assign unused_mem_ld = mem_q.ld;

    function automatic logic writes(input logic v, input logic rw,
                                    input logic [REG_ADDR_W-1:0] rd,
                                    input logic [REG_ADDR_W-1:0] r);
        return v && rw && (rd != '0) && (rd == r);
    endfunction

    always_comb begin
        lu = ex_q.v && ex_q.ld && ex_q.rw && (ex_q.rd != '0) && id_valid &&
             ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
        bubble_e = ex_branch_taken || lu;

        fa_mem = ex_q.v && writes(mem_q.v, mem_q.rw, mem_q.rd, ex_q.rs1);
        fa_wb  = ex_q.v && writes(wb_q.v, wb_q.rw, wb_q.rd, ex_q.rs1) && !fa_mem;
        fb_mem = ex_q.v && writes(mem_q.v, mem_q.rw, mem_q.rd, ex_q.rs2);
        fb_wb  = ex_q.v && writes(wb_q.v, wb_q.rw, wb_q.rd, ex_q.rs2) && !fb_mem;
    end

    // Shadow pipeline advances every cycle; only IF/ID is held on a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= {mem_q.v, mem_q.rd, mem_q.rw};
            mem_q <= {ex_q.v, ex_q.rd, ex_q.rw, ex_q.ld};
            ex_q  <= {id_valid && !bubble_e, id_rs1, id_rs2, id_rd, id_regwrite, id_is_load};
        end
    end

    // Branch wins over load-use: the dependent instruction is flushed, so no stall.
    always_comb begin
        fwd_a_mem = !reset && fa_mem;
        fwd_a_wb  = !reset && fa_wb;
        fwd_b_mem = !reset && fb_mem;
        fwd_b_wb  = !reset && fb_wb;
        stall_f   = !reset && lu && !ex_branch_taken;
        stall_d   = !reset && lu && !ex_branch_taken;
        flush_d   = !reset && ex_branch_taken;
        flush_e   = !reset && bubble_e;
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_d) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_d) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: directed instruction stream, monitor compares every cycle.
module tb_fwd_hazard_ctrl;
    localparam int AW = 5;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_regwrite = 1'b0, id_is_load = 1'b0, ex_branch_taken = 1'b0;
    logic          fwd_a_mem, fwd_a_wb, fwd_b_mem, fwd_b_wb;
    logic          stall_f, stall_d, flush_d, flush_e;
    logic [CW-1:0] stall_count, flush_count;

    fwd_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken),
        .fwd_a_mem(fwd_a_mem), .fwd_a_wb(fwd_a_wb), .fwd_b_mem(fwd_b_mem), .fwd_b_wb(fwd_b_wb),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [7:0]    sig;   // {a_mem,a_wb,b_mem,b_wb,stall_f,stall_d,flush_d,flush_e}
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t          sbq[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            step_no = 0;
    logic [CW-1:0] tally_s = '0, tally_f = '0;

    task automatic step(input logic rst, input logic v,
                        input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                        input logic rw, input logic ld, input logic bt, input logic [7:0] exp_sig);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_regwrite = rw; id_is_load = ld; ex_branch_taken = bt;
        if (rst) begin
            tally_s = '0;
            tally_f = '0;
        end
        e.idx = step_no;
        e.sig = exp_sig;
`ifdef HAZARD_STATS_EN
        e.sc = tally_s;
        e.fc = tally_f;
`else
        e.sc = '0;
        e.fc = '0;
`endif
        sbq.push_back(e);
        if (exp_sig[2]) tally_s = tally_s + 1;
        if (exp_sig[1]) tally_f = tally_f + 1;
        step_no++;
    endtask

    // Monitor: outputs are combinational, so every cycle presents one response.
    initial begin
        exp_t e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                act = {fwd_a_mem, fwd_a_wb, fwd_b_mem, fwd_b_wb, stall_f, stall_d, flush_d, flush_e};
                n_chk++;
                if (act !== e.sig || stall_count !== e.sc || flush_count !== e.fc) begin
                    n_fail++;
                    $display("FAIL step%0d: got sig=%b sc=%0d fc=%0d, expected sig=%b sc=%0d fc=%0d",
                             e.idx, act, stall_count, flush_count, e.sig, e.sc, e.fc);
                end
            end
        end
    end

    initial begin
        //         rst v  rs1 rs2 rd  rw ld bt  expected
        step(1, 1, 5'd3, 5'd4, 5'd9, 1, 1, 0, 8'b0000_0000); // reset state
        step(0, 1, 5'd1, 5'd2, 5'd5, 1, 0, 0, 8'b0000_0000); // add x5
        step(0, 1, 5'd5, 5'd1, 5'd6, 1, 0, 0, 8'b0000_0000); // sub x6,x5,x1
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 8'b1000_0000); // sub in EX: A from MEM
        step(0, 1, 5'd3, 5'd4, 5'd7, 1, 0, 0, 8'b0000_0000); // add x7
        step(0, 1, 5'd11,5'd12,5'd10,1, 0, 0, 8'b0000_0000); // unrelated
        step(0, 1, 5'd1, 5'd7, 5'd13,1, 0, 0, 8'b0000_0000); // and x13,x1,x7
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 8'b0001_0000); // B from WB
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 8'b0000_0000); // only one cycle
        step(0, 1, 5'd2, 5'd0, 5'd8, 1, 1, 0, 8'b0000_0000); // lw x8
        step(0, 1, 5'd8, 5'd8, 5'd9, 1, 0, 0, 8'b0000_1101); // add x9,x8,x8: load-use
        step(0, 1, 5'd8, 5'd8, 5'd9, 1, 0, 0, 8'b0000_0000); // held, bubble in EX
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 8'b0101_0000); // both operands from WB
        step(0, 1, 5'd2, 5'd0, 5'd14,1, 1, 0, 8'b0000_0000); // lw x14
        step(0, 1, 5'd14,5'd1, 5'd15,1, 0, 1, 8'b0000_0011); // load-use + branch: branch wins
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 8'b0000_0000);
        step(0, 1, 5'd1, 5'd2, 5'd0, 1, 0, 0, 8'b0000_0000); // add x0
        step(0, 1, 5'd0, 5'd0, 5'd16,1, 0, 0, 8'b0000_0000); // consumer of x0
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 8'b0000_0000); // no forward of x0
        step(0, 1, 5'd1, 5'd0, 5'd0, 1, 1, 0, 8'b0000_0000); // lw x0
        step(0, 1, 5'd0, 5'd0, 5'd17,1, 0, 0, 8'b0000_0000); // no stall on x0 load
        step(0, 1, 5'd1, 5'd1, 5'd20,1, 0, 0, 8'b0000_0000); // add x20 (older)
        step(0, 1, 5'd2, 5'd2, 5'd20,1, 0, 0, 8'b0000_0000); // add x20 (younger)
        step(0, 1, 5'd3, 5'd20,5'd21,1, 0, 0, 8'b0000_0000); // add x21,x3,x20
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 8'b0010_0000); // MEM beats WB
        step(0, 1, 5'd1, 5'd2, 5'd22,0, 0, 0, 8'b0000_0000); // non-writing rd=x22
        step(0, 1, 5'd22,5'd22,5'd23,1, 0, 0, 8'b0000_0000);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 8'b0000_0000); // rw=0 never forwarded
        step(0, 1, 5'd1, 5'd2, 5'd24,1, 0, 0, 8'b0000_0000); // add x24
        step(0, 1, 5'd1, 5'd0, 5'd26,1, 1, 0, 8'b0000_0000); // lw x26
        step(1, 1, 5'd26,5'd24,5'd27,1, 0, 0, 8'b0000_0000); // reset over a pending load-use
        step(0, 1, 5'd24,5'd26,5'd28,1, 0, 0, 8'b0000_0000); // matches pre-reset rds
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 8'b0000_0000); // shadow was wiped
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 8'b0000_0000);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 8'b0000_0011); // plain taken branch
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 8'b0000_0000);

        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d responses pending, expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control-side counterpart of the pipeline's 2:1 operand/result muxes. This block generates every select, stall and flush those muxes and pipeline registers consume.
- It keeps a private shadow of destination-register info for the EX, MEM and WB stages. It produces:
  - EX operand forwarding selects, as two cascaded mux2 select bits per operand;
  - the load-use stall;
  - branch-taken flushes.
- Sits beside the ID/EX boundary. The core only supplies ID-stage register fields and the EX branch outcome.

Parameters:
- REG_ADDR_W, 5, register-index width; index 0 is hardwired zero and never forwarded or hazarded.
- CNT_W, 32, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_ADDR_W  ID source register 1.
- id_rs2  in  REG_ADDR_W  ID source register 2.
- id_rd  in  REG_ADDR_W  ID destination register.
- id_regwrite  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- ex_branch_taken  in  1  EX branch/jump resolved taken this cycle.
- fwd_a_mem  out  1  EX operand A mux2 select: 1 = MEM ALU result.
- fwd_a_wb  out  1  EX operand A mux2 select: 1 = WB result; fwd_a_mem has priority.
- fwd_b_mem  out  1  EX operand B mux2 select: 1 = MEM ALU result.
- fwd_b_wb  out  1  EX operand B mux2 select: 1 = WB result; fwd_b_mem has priority.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold IF/ID register.
- flush_d  out  1  clear IF/ID register.
- flush_e  out  1  insert bubble into ID/EX register.
- stall_count  out  CNT_W  load-use stall cycles (optional feature).
- flush_count  out  CNT_W  taken-branch flushes (optional feature).

Behaviour:
- Shadow state:
  - EX entry: {v, rs1, rs2, rd, rw, ld}.
  - MEM entry: {v, rd, rw, ld}.
  - WB entry: {v, rd, rw}.
- Every rising edge:
  - WB <= MEM; MEM <= EX.
  - If flush_e, EX.v <= 0; otherwise EX <= ID fields, with v = id_valid.
  - The shadow never stalls; only IF/ID stalls.
- Reset: all v bits cleared asynchronously, counters cleared. While reset is high, all outputs are forced to 0.
- Define the predicate "writes r" for a stage as: v && rw && rd != 0 && rd == r.
- Forwarding, combinational from shadow state only:
  - fwd_a_mem = MEM writes EX.rs1.
  - fwd_a_wb = WB writes EX.rs1 && !fwd_a_mem.
  - Operand B is identical using EX.rs2.
  - All four selects are 0 when EX.v = 0.
- Load-use hazard:
  - lu = EX.v && EX.ld && EX.rw && EX.rd != 0 && id_valid && (EX.rd == id_rs1 || EX.rd == id_rs2).
  - One-cycle stall. After the bubble, the load sits in WB when the dependent instruction reaches EX, so it takes the WB path.
- Outputs:
  - stall_f = stall_d = lu && !ex_branch_taken.
  - flush_d = ex_branch_taken.
  - flush_e = ex_branch_taken || lu.
- Simultaneous branch-taken and load-use: the branch wins. No stall; ID is flushed and EX gets a bubble.
- A MEM-stage load that matches EX.rs cannot occur because lu prevents it. The block forwards anyway and does not check.
- rd = 0 producers are never forwarded and never stall.
- Same-cycle WB-to-ID read is the register file's responsibility (write-first); it is outside this block.
- Reset asserted mid-operation: shadow entries are invalidated immediately, and no forwards are issued on the first post-reset cycle.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - stall_count increments on every clk where stall_d = 1.
  - flush_count increments on every clk where flush_d = 1.
  - Both counters wrap modulo 2^CNT_W and reset to 0.
- Undefined: both ports remain present and tied to 0, and no counter flops are inferred.

Test Plan:
- Back-to-back add x5 then sub x6,x5,x1: next cycle fwd_a_mem = 1, fwd_a_wb = 0, fwd_b_* = 0; no stall.
- Producer x7, then unrelated, then consumer rs2 = x7: fwd_b_wb = 1 for one cycle, fwd_b_mem = 0.
- lw x8, then add x9,x8,x8: one cycle with stall_f = stall_d = flush_e = 1. The next cycle, EX sees both fwd_a_wb = 1 and fwd_b_wb = 1. stall_count = 1 when HAZARD_STATS_EN.
- lw x8 in EX, dependent in ID, ex_branch_taken = 1 the same cycle: flush_d = flush_e = 1, stall_f = 0. flush_count +1, stall_count unchanged.
- Producer with rd = x0, then consumer of x0: all fwd outputs 0, no stall.
- Pipeline full of valid producers, assert reset for one cycle mid-stream: all outputs 0 during reset. On the first cycle after release, fwd outputs are 0 even if ID matches a pre-reset rd.
